// File: rtl/rv32i_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_multicycle_ctrl
// Description : Multi-cycle control FSM for the RV32I core. Steps each
//               instruction through FETCH, DECODE, EXEC, MEM and WB, drives
//               the shared memory port, the IR/MDR/PC/register-file write
//               enables and the ALU/PC/writeback mux selects, and counts
//               retired instructions. Halts in TRAP on an illegal opcode or
//               when memory fails to respond within MEM_TIMEOUT cycles.
// Ports       : clk, rst (async, active-high)
//               opcode, branch_taken, mem_ready   - decode/datapath inputs
//               mem_req, mem_we, addr_sel         - memory port control
//               ir_we, mdr_we, pc_we, reg_we      - write strobes
//               pc_src, alu_a_sel, alu_b_sel, wb_sel - mux selects
//               trap, trap_cause, state, instret  - status
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 ir_we,
  output logic                 mdr_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 alu_a_sel,
  output logic                 alu_b_sel,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic [1:0]             trap_cause_q, trap_cause_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_opimm, is_op, is_fence, is_legal;
  logic retire;
  logic tmo_hit;

  always_comb begin
    is_lui    = (opcode == OPC_LUI);
    is_auipc  = (opcode == OPC_AUIPC);
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    is_branch = (opcode == OPC_BRANCH);
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_opimm  = (opcode == OPC_OPIMM);
    is_op     = (opcode == OPC_OP);
    is_fence  = (opcode == OPC_FENCE);
    is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                is_load | is_store | is_opimm | is_op | is_fence;
  end

  // The counter holds the number of stalled cycles already spent in the
  // current FETCH/MEM visit; the trap fires on the stalled cycle that would
  // bring it to the limit. A ready on that cycle takes priority.
  always_comb begin
    tmo_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
              ((state_q == ST_FETCH) || (state_q == ST_MEM)) &&
              ((tmo_q + TMO_W'(1)) == TMO_LIMIT);
  end

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    tmo_d        = '0;
    retire       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DECODE: begin
        if (is_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d      = ST_TRAP;
          trap_cause_d = 2'd1;
        end
      end
      ST_EXEC: begin
        if (is_load || is_store) begin
          state_d = ST_MEM;
        end else if (is_branch || is_fence) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (is_store) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    instret_d = retire ? (instret_q + INSTRET_W'(1)) : instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      instret_q    <= '0;
      trap_cause_q <= 2'd0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      instret_q    <= instret_d;
      trap_cause_q <= trap_cause_d;
      tmo_q        <= tmo_d;
    end
  end

  // Control outputs follow the current state; the memory-handshake strobes
  // also depend on mem_ready so they fire only on the accepting cycle.
  // Everything is held low while rst is asserted.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          ir_we    = mem_ready;
        end
        ST_EXEC: begin
          alu_a_sel = is_auipc | is_jal | is_branch;
          alu_b_sel = !(is_op | is_branch);
          if (is_branch) begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? 2'd1 : 2'd0;
          end else if (is_fence) begin
            pc_we = 1'b1;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          mdr_we  = mem_ready & is_load;
          pc_we   = mem_ready & is_store;
        end
        ST_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          wb_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
          pc_src = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        end
        default: begin
        end
      endcase
    end
  end

  assign state      = state_q;
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = trap_cause_q;
  assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_multicycle_ctrl
// Description : Self-checking bench for rv32i_multicycle_ctrl. Each
//               instruction is planned as a list of states to visit (from
//               its opcode class and the chosen memory stalls); the expected
//               control outputs for every cycle of that plan are compared
//               with the design, along with the retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_multicycle_ctrl;

  localparam int TMO = 16;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;
  localparam logic [6:0] FENCE = 7'b0001111, SYS = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
  logic [1:0]  pc_src, wb_sel, trap_cause;
  logic        alu_a_sel, alu_b_sel, reg_we, trap;
  logic [2:0]  state;
  logic [31:0] instret;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_ret = '0;
  logic [6:0]  legal_ops [10] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPIMM, OP, FENCE};

  rv32i_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // {state, mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src,
  //  alu_a_sel, alu_b_sel, reg_we, wb_sel, trap}
  logic [16:0] dut_vec;
  assign dut_vec = {state, mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we,
                    pc_src, alu_a_sel, alu_b_sel, reg_we, wb_sel, trap};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word for one cycle spent in phase 'ph' of an instruction.
  function automatic logic [16:0] expect_word(int ph, logic [6:0] op, bit rdy, bit tk);
    bit req = 0, we = 0, asel = 0, irw = 0, mdrw = 0, pcw = 0, aa = 0, bb = 0, rw = 0;
    logic [1:0] psrc = 0, wsel = 0;
    case (ph)
      0: begin req = 1; asel = 1; irw = rdy; end
      2: begin
        aa = (op == AUIPC) || (op == JAL) || (op == BR);
        bb = !((op == OP) || (op == BR));
        if (op == BR)    begin pcw = 1; psrc = tk ? 2'd1 : 2'd0; end
        if (op == FENCE) pcw = 1;
      end
      3: begin req = 1; we = (op == ST); mdrw = rdy && (op == LD); pcw = rdy && (op == ST); end
      4: begin
        rw = 1; pcw = 1;
        wsel = (op == LD) ? 2'd1 : ((op == JAL || op == JALR) ? 2'd2 : 2'd0);
        psrc = (op == JAL) ? 2'd1 : ((op == JALR) ? 2'd2 : 2'd0);
      end
      default: ;
    endcase
    return {3'(ph), req, we, asel, irw, mdrw, pcw, psrc, aa, bb, rw, wsel, bit'(ph == 5)};
  endfunction

  // One cycle: drive on the falling edge, check 1 ns later.
  task automatic cyc(input string tag, input int ph, input logic [6:0] op,
                     input bit rdy, input bit tk);
    @(negedge clk);
    opcode = op; mem_ready = rdy; branch_taken = tk;
    #1;
    check(tag, 32'(dut_vec), 32'(expect_word(ph, op, rdy, tk)));
    check({tag, "_instret"}, instret, exp_ret);
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op,
                           input int fwait, input int mwait, input bit tk);
    for (int i = 0; i < fwait; i++) cyc({tag, "_fetch_wait"}, 0, 7'($urandom), 1'b0, 1'($urandom));
    cyc({tag, "_fetch"}, 0, 7'($urandom), 1'b1, 1'($urandom));
    cyc({tag, "_decode"}, 1, op, 1'($urandom), 1'($urandom));
    cyc({tag, "_exec"}, 2, op, 1'($urandom), tk);
    if (op == LD || op == ST) begin
      for (int i = 0; i < mwait; i++) cyc({tag, "_mem_wait"}, 3, op, 1'b0, 1'($urandom));
      cyc({tag, "_mem"}, 3, op, 1'b1, 1'($urandom));
    end
    if (!(op == BR || op == FENCE || op == ST))
      cyc({tag, "_wb"}, 4, op, 1'($urandom), 1'($urandom));
    exp_ret = exp_ret + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    exp_ret = '0;
    check("reset_word", 32'(dut_vec), 32'd0);
    check("reset_instret", instret, 32'd0);
    check("reset_cause", 32'(trap_cause), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Directed instructions
    run_instr("addi", OPIMM, 0, 0, 1'b0);
    run_instr("lw", LD, 0, 3, 1'b0);
    run_instr("beq_taken", BR, 0, 0, 1'b1);
    run_instr("bne_not_taken", BR, 0, 0, 1'b0);
    run_instr("jalr", JALR, 0, 0, 1'b0);
    run_instr("sw", ST, 0, 0, 1'b0);
    run_instr("jal", JAL, 1, 0, 1'b0);
    run_instr("fence", FENCE, 0, 0, 1'b1);
    // Ready arriving on the last permitted stall cycle beats the timeout
    run_instr("fetch_edge", OP, TMO - 1, 0, 1'b0);
    run_instr("mem_edge", LD, 0, TMO - 1, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      op = legal_ops[$urandom_range(0, 9)];
      run_instr("rand", op, ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom));
    end

    // Reset asserted mid-MEM of a store
    cyc("rst_sw_fetch", 0, 7'($urandom), 1'b1, 1'b0);
    cyc("rst_sw_decode", 1, ST, 1'b0, 1'b0);
    cyc("rst_sw_exec", 2, ST, 1'b0, 1'b0);
    cyc("rst_sw_mem", 3, ST, 1'b0, 1'b0);
    do_reset();
    cyc("post_rst", 0, 7'($urandom), 1'b0, 1'b0);
    run_instr("post_rst_addi", OPIMM, 0, 0, 1'b0);

    // Illegal opcode
    cyc("ill_fetch", 0, 7'($urandom), 1'b1, 1'b0);
    cyc("ill_decode", 1, SYS, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc("ill_trap", 5, 7'($urandom), 1'($urandom), 1'($urandom));
      check("ill_cause", 32'(trap_cause), 32'd1);
    end

    // Fetch timeout
    do_reset();
    run_instr("pre_tmo", LUI, 0, 0, 1'b0);
    for (int i = 0; i < TMO; i++) cyc("tmo_fetch", 0, 7'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc("tmo_trap", 5, 7'($urandom), 1'($urandom), 1'($urandom));
      check("tmo_cause", 32'(trap_cause), 32'd2);
    end

    // Memory-phase timeout on a load
    do_reset();
    cyc("mtmo_fetch", 0, 7'($urandom), 1'b1, 1'b0);
    cyc("mtmo_decode", 1, LD, 1'b0, 1'b0);
    cyc("mtmo_exec", 2, LD, 1'b0, 1'b0);
    for (int i = 0; i < TMO; i++) cyc("mtmo_mem", 3, LD, 1'b0, 1'b0);
    cyc("mtmo_trap", 5, LD, 1'b1, 1'b0);
    check("mtmo_cause", 32'(trap_cause), 32'd2);

    do_reset();
    cyc("final_fetch", 0, 7'($urandom), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
